store_req_queue: RTL

Store-side memory request unit for the SRAM-like data port, replacing the combinational EX store formatter with a parametrised, buffered version. It accepts store micro-ops from EX and formats data, strobe and size for sb/sh/sw/swl/swr on a 32- or 64-bit bus. It also raises AdES, queues up to DEPTH committed stores, and drives the two-phase request handshake (addr_ok, then data_ok), retiring entries in order.

---
 rtl/store_req_if.sv | 19 +
 rtl/store_req_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/store_req_if.sv
// store_req_if: two-phase store request bus; master drives the request, slave returns addr_ok/data_ok
interface store_req_if #(parameter int DATA_W = 32) ();
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [31:0]           data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W/8-1:0]   data_strb;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_strb,
    input  data_addr_ok, data_data_ok
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_strb,
    output data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/store_req_queue.sv
// store_req_queue: formats sb/sh/sw/swl/swr from EX (in_*), raises AdES, queues DEPTH stores and issues them in order on bus (store_req_if.master); ld_addr/ld_conflict check enabled by STQ_LD_CONFLICT_EN, empty when drained
module store_req_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [4:0]  in_dtl,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rt_data,
  input  logic        MEM_exception,
  output logic        in_ready,
  output logic        AdES_exception,
  store_req_if.master bus,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        empty
);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OB = $clog2(SW);
  logic [1:0]        ea;
  logic              lane;
  logic [31:0]       f_raw, f_data, f_addr;
  logic [3:0]        f_strb;
  logic [1:0]        f_size;
  logic              one_hot, push, issue, retire;
  logic [PW-1:0]     tail, iss, head;
  logic [CW-1:0]     cnt, out;
  logic [31:0]       q_addr  [DEPTH];
  logic [1:0]        q_size  [DEPTH];
  logic [DATA_W-1:0] q_wdata [DEPTH];
  logic [SW-1:0]     q_strb  [DEPTH];
  assign ea   = in_addr[1:0];
  assign lane = (DATA_W == 64) ? in_addr[2] : 1'b0;
  always_comb begin
    f_raw  = in_dtl[3] ? in_rt_data >> {~ea, 3'b0} : in_rt_data << {ea, 3'b0};
    f_strb = in_dtl[0] ? 4'hf
           : in_dtl[1] ? 4'b0001 << ea
           : in_dtl[2] ? (ea[1] ? 4'b1100 : 4'b0011)
           : in_dtl[3] ? 4'hf >> ~ea
           : 4'hf << ea;
    f_data = f_raw & {{8{f_strb[3]}}, {8{f_strb[2]}}, {8{f_strb[1]}}, {8{f_strb[0]}}};
    f_size = in_dtl[1] ? 2'd0
           : in_dtl[2] ? 2'd1
           : in_dtl[3] ? (ea == 2'd0 ? 2'd0 : ea == 2'd1 ? 2'd1 : 2'd2)
           : in_dtl[4] ? (ea == 2'd3 ? 2'd0 : ea == 2'd2 ? 2'd1 : 2'd2)
           : 2'd2;
    f_addr = in_dtl[3] ? {in_addr[31:2], 2'b00} : in_addr;
  end
  assign one_hot        = (in_dtl != 5'd0) && ((in_dtl & (in_dtl - 5'd1)) == 5'd0);
  assign AdES_exception = in_en & ((in_dtl[0] & (ea != 2'd0)) | (in_dtl[2] & ea[0]));
  assign in_ready       = cnt != CW'(DEPTH);
  assign empty          = cnt == '0;
  assign push           = in_en & in_ready & ~MEM_exception & ~AdES_exception & one_hot;
  assign issue          = bus.data_req & bus.data_addr_ok;
  assign retire         = bus.data_data_ok & (out != '0);
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail]  <= f_addr;
      q_size[tail]  <= f_size;
      q_wdata[tail] <= DATA_W'(f_data) << {lane, 5'b0};
      q_strb[tail]  <= SW'(f_strb) << {lane, 2'b0};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tail <= '0;
      iss  <= '0;
      head <= '0;
      cnt  <= '0;
      out  <= '0;
    end else begin
      tail <= tail + PW'(push);
      iss  <= iss + PW'(issue);
      head <= head + PW'(retire);
      cnt  <= cnt + CW'(push) - CW'(retire);
      out  <= out + CW'(issue) - CW'(retire);
    end
  end
  // unissued entries exist exactly when more are valid than are outstanding
  assign bus.data_req   = cnt > out;
  assign bus.data_wr    = bus.data_req;
  assign bus.data_addr  = q_addr[iss];
  assign bus.data_size  = q_size[iss];
  assign bus.data_wdata = q_wdata[iss];
  assign bus.data_strb  = q_strb[iss];
`ifdef STQ_LD_CONFLICT_EN
  logic [PW-1:0] off;
  logic          unused_ld;
  assign unused_ld = ^ld_addr[OB-1:0];
  always_comb begin
    ld_conflict = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < cnt && q_addr[i][31:OB] == ld_addr[31:OB]) ld_conflict = 1'b1;
    end
  end
`else
  logic unused_ld;
  assign unused_ld   = ^ld_addr;
  assign ld_conflict = 1'b0;
`endif
endmodule
